// File: rtl/hit_reducer.sv
// rtl/hit_reducer.sv - nearest forward hit selector across the spheres of one pixel
module hit_reducer #(
  parameter int SPHERE_COUNT = 4,
  parameter int T_W          = 12,
  parameter int IDX_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_hit,
  input  logic signed [T_W-1:0] in_t,
  input  logic [23:0]           in_color,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_hit,
  output logic [IDX_W-1:0]      out_idx,
  output logic signed [T_W-1:0] out_t,
  output logic [23:0]           out_color,
  output logic                  out_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int CNT_W = $clog2(SPHERE_COUNT + 1);
  // Count of previously accepted beats at which the current beat is the last allowed one
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPHERE_COUNT - 1);
  // Largest positive distance: "nothing hit yet" and the no-hit result value
  localparam logic signed [T_W-1:0] T_FAR  = {1'b0, {(T_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] T_ZERO = '0;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                best_hit;
  logic [IDX_W-1:0]    best_idx;
  logic signed [T_W-1:0] best_t;
  logic [23:0]         best_color;
  logic                err;

  logic accept;
  logic qualify;
  logic replace;
  logic closing;

  assign accept  = in_valid && in_ready;
  // Zero or negative distance is behind the camera
  assign qualify = in_hit && (in_t > T_ZERO);
  // Strict less-than so that ties keep the earlier beat
  assign replace = !best_hit || (in_t < best_t);
  assign closing = in_last || (cnt == CNT_LAST);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_hit   = best_hit;
  assign out_idx   = best_idx;
  assign out_t     = best_t;
  assign out_color = best_color;
  assign out_err   = err;

  // Pixel FSM: clear on start, fold in accepted beats, hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      best_hit   <= 1'b0;
      best_idx   <= '0;
      best_t     <= T_FAR;
      best_color <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= '0;
            best_hit   <= 1'b0;
            best_idx   <= '0;
            best_t     <= T_FAR;
            best_color <= '0;
            err        <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (qualify && replace) begin
              best_hit   <= 1'b1;
              best_idx   <= in_idx;
              best_t     <= in_t;
              best_color <= in_color;
            end
            cnt <= cnt + 1'b1;
            if (closing) begin
              // Closed without in_last means the beat budget ran out
              err   <= !in_last;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_reducer.sv
// tb/tb_hit_reducer.sv - directed bench with a nearest-hit model for hit_reducer
module tb_hit_reducer;

  localparam int SPHERE_COUNT = 4;
  localparam int T_W          = 12;
  localparam int IDX_W        = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [IDX_W-1:0]      in_idx;
  logic                  in_hit;
  logic signed [T_W-1:0] in_t;
  logic [23:0]           in_color;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_hit;
  logic [IDX_W-1:0]      out_idx;
  logic signed [T_W-1:0] out_t;
  logic [23:0]           out_color;
  logic                  out_err;
  logic                  busy;

  hit_reducer #(
    .SPHERE_COUNT(SPHERE_COUNT),
    .T_W(T_W),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_idx(in_idx), .in_hit(in_hit), .in_t(in_t), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_idx(out_idx), .out_t(out_t),
    .out_color(out_color), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic signed [T_W-1:0] t;
    logic                  last;
  } beat_t;

  beat_t beats_q[$];

  int n_checks = 0;
  int n_err    = 0;

  logic                  m_hit;
  logic [IDX_W-1:0]      m_idx;
  logic signed [T_W-1:0] m_t;
  logic [23:0]           m_color;
  logic                  m_err;
  int                    m_consumed;

  function automatic logic [23:0] col(input logic [IDX_W-1:0] idx);
    return {idx, idx ^ 8'hA5, ~idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int idx, input logic hit, input int t, input logic last);
    beat_t b;
    b.idx  = IDX_W'(idx);
    b.hit  = hit;
    b.t    = T_W'(t);
    b.last = last;
    beats_q.push_back(b);
  endtask

  // Expected result: which beats belong to the pixel, then the smallest forward t, earliest on ties
  task automatic model();
    int n = 0;
    int min_t = 1 << 30;
    m_consumed = 0;
    foreach (beats_q[i]) begin
      n++;
      if (beats_q[i].last || n == SPHERE_COUNT) break;
    end
    m_consumed = n;
    m_err = !beats_q[n-1].last;
    for (int i = 0; i < n; i++)
      if (beats_q[i].hit && int'(beats_q[i].t) > 0 && int'(beats_q[i].t) < min_t)
        min_t = int'(beats_q[i].t);
    m_hit = 1'b0; m_idx = '0; m_t = 12'sh7FF; m_color = '0;
    for (int i = 0; i < n; i++) begin
      if (!m_hit && beats_q[i].hit && int'(beats_q[i].t) == min_t && min_t > 0) begin
        m_hit   = 1'b1;
        m_idx   = beats_q[i].idx;
        m_t     = beats_q[i].t;
        m_color = col(beats_q[i].idx);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whenever a result is presented it must equal the model and stay put while stalled
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("cmp_hit",   32'(out_hit),   32'(m_hit));
      chk("cmp_idx",   32'(out_idx),   32'(m_idx));
      chk("cmp_t",     32'(out_t),     32'(m_t));
      chk("cmp_color", 32'(out_color), 32'(m_color));
      chk("cmp_err",   32'(out_err),   32'(m_err));
      chk("cmp_busy",  32'(busy),      32'd1);
    end
  end

  // Drive one pixel from beats_q; stall the result for hold cycles, optionally pulsing start
  task automatic run_pixel(input int hold, input logic pulse_start, input logic junk_with_start);
    model();
    start = 1'b1;
    if (junk_with_start) begin
      in_valid = 1'b1; in_hit = 1'b1; in_t = 12'sd1; in_idx = 8'hEE;
      in_color = col(8'hEE); in_last = 1'b1;
    end
    step();
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_busy",  32'(busy),     32'd1);
    chk("start_nov",   32'(out_valid), 32'd0);
    foreach (beats_q[i]) begin
      in_valid = 1'b1;
      in_idx   = beats_q[i].idx;
      in_hit   = beats_q[i].hit;
      in_t     = beats_q[i].t;
      in_color = col(beats_q[i].idx);
      in_last  = beats_q[i].last;
      chk(i < m_consumed ? "beat_ready" : "hold_not_ready", 32'(in_ready),
          i < m_consumed ? 32'd1 : 32'd0);
      step();
      if (i == m_consumed - 1) chk("latency_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int c = 0; c < hold; c++) begin
      start = pulse_start;
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_busy",  32'(busy),      32'd1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_busy",  32'(busy),      32'd0);
    beats_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_idx = '0;
    in_hit = 1'b0; in_t = '0; in_color = '0; out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_hit",   32'(out_hit),   32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_t",     32'(out_t),     32'h7FF);
    chk("rst_color", 32'(out_color), 32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    step();
    step();
    rst = 1'b0;

    // in_valid without start in IDLE is ignored
    in_valid = 1'b1; in_hit = 1'b1; in_t = 12'sd3; in_last = 1'b1;
    step();
    step();
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_busy",  32'(busy),     32'd0);
    in_valid = 1'b0; in_last = 1'b0;

    // Nearest selection
    add_beat(0, 1'b1, 40, 1'b0);
    add_beat(1, 1'b1, 24, 1'b0);
    add_beat(2, 1'b1, 56, 1'b1);
    model();
    chk("pin_near_idx", 32'(m_idx), 32'd1);
    chk("pin_near_t",   32'(m_t),   32'd24);
    chk("pin_near_err", 32'(m_err), 32'd0);
    run_pixel(0, 1'b0, 1'b0);

    // All miss
    for (int i = 0; i < 4; i++) add_beat(i, 1'b0, 10 + i, i == 3);
    model();
    chk("pin_miss_hit", 32'(m_hit), 32'd0);
    chk("pin_miss_t",   32'(m_t),   32'h7FF);
    run_pixel(1, 1'b0, 1'b0);

    // Tie keeps earlier; a beat alongside start is not accepted
    add_beat(0, 1'b1, 32, 1'b0);
    add_beat(1, 1'b1, 32, 1'b1);
    model();
    chk("pin_tie_idx", 32'(m_idx), 32'd0);
    run_pixel(0, 1'b0, 1'b1);

    // Behind-camera rejection
    add_beat(0, 1'b1, -8, 1'b0);
    add_beat(1, 1'b1, 0, 1'b0);
    add_beat(2, 1'b1, 100, 1'b1);
    model();
    chk("pin_rej_idx", 32'(m_idx), 32'd2);
    chk("pin_rej_t",   32'(m_t),   32'd100);
    run_pixel(0, 1'b0, 1'b0);

    // Backpressure with start pulses, then a pixel starting right after the handshake
    add_beat(3, 1'b1, 70, 1'b0);
    add_beat(5, 1'b1, 15, 1'b1);
    run_pixel(5, 1'b1, 1'b0);
    add_beat(7, 1'b1, 2047, 1'b0);
    add_beat(6, 1'b1, 9, 1'b1);
    run_pixel(0, 1'b0, 1'b0);

    // Reset mid-pixel
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_hit = 1'b1; in_last = 1'b0;
    in_idx = 8'd0; in_t = 12'sd5; in_color = col(8'd0);
    step();
    in_idx = 8'd1; in_t = 12'sd6; in_color = col(8'd1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_hit",   32'(out_hit),   32'd0);
    chk("mid_rst_t",     32'(out_t),     32'h7FF);
    chk("mid_rst_color", 32'(out_color), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    add_beat(4, 1'b1, 50, 1'b0);
    add_beat(5, 1'b1, 30, 1'b0);
    add_beat(6, 1'b1, 70, 1'b1);
    model();
    chk("pin_rst_idx", 32'(m_idx), 32'd5);
    run_pixel(0, 1'b0, 1'b0);

    // Missing last: closes on the 4th beat with error, 5th beat refused in HOLD
    add_beat(0, 1'b1, 60, 1'b0);
    add_beat(1, 1'b0, 20, 1'b0);
    add_beat(2, 1'b1, 45, 1'b0);
    add_beat(3, 1'b1, 50, 1'b0);
    add_beat(4, 1'b1, 1, 1'b0);
    model();
    chk("pin_cnt_err", 32'(m_err), 32'd1);
    chk("pin_cnt_idx", 32'(m_idx), 32'd2);
    run_pixel(2, 1'b0, 1'b0);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
